// File: rtl/cpu_bus_responder.sv
// CPU external-bus target: control registers, table write/read pulses, tri-state read data.
// Latency: write visible 2 CLK after WE_N rise, read OE after TBL_LAT+3 CLK; no backpressure, CPU holds strobes.
module cpu_bus_responder #(
    parameter int          WIDTH            = 13,
    parameter int          TRANS_NUM        = 249,
    parameter int          TBL_LAT          = 2,
    parameter logic [15:0] VERSION          = 16'h0001,
    parameter int          STEP_RST         = 100,
    parameter int          UPDATE_CYCLE_RST = 1250
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [15:0]      CPU_ADDR,
    input  logic [15:0]      CPU_DATA_IN,
    output logic [15:0]      CPU_DATA_OUT,
    output logic             CPU_DATA_OE,
    input  logic             CPU_CS1_N,
    input  logic             CPU_WE0_N,
    input  logic             CPU_RD_N,
    output logic             TBL_WE,
    output logic             TBL_RE,
    output logic [1:0]       TBL_SEL,
    output logic [7:0]       TBL_ADDR,
    output logic [15:0]      TBL_WDATA,
    input  logic [15:0]      TBL_RDATA,
    output logic [WIDTH-1:0] STEP,
    output logic [WIDTH-1:0] UPDATE_CYCLE,
    output logic             FORCE_FAN,
    output logic [3:0]       GPIO_OUT
);

    localparam logic [8:0] TN = 9'(TRANS_NUM);
    localparam int         CW = (TBL_LAT > 1) ? $clog2(TBL_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TBL_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRIVE} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;

    // stage S: registered pins; stage P: the previous S sample
    logic           s_cs_n, s_we_n, s_rd_n;
    logic [1:0]     s_bank;
    logic [7:0]     s_idx;
    logic [15:0]    s_data;
    logic           p_cs_n, p_we_n;
    logic [1:0]     p_bank;
    logic [7:0]     p_idx;
    logic [15:0]    p_data;
    logic [1:0]     r_bank;
    logic [7:0]     r_idx;

    logic           unused_addr;
    logic           commit, rd_hold, rd_start;
    logic [15:0]    ctl_rdata;

    assign unused_addr = ^CPU_ADDR[13:8];

    function automatic logic in_range(input logic [7:0] idx);
        return {1'b0, idx} < TN;
    endfunction

    assign commit   = s_we_n & ~p_we_n & ~p_cs_n;
    assign rd_hold  = ~s_rd_n & ~s_cs_n;
    assign rd_start = rd_hold & s_we_n;

    always_comb begin
        ctl_rdata = 16'h0000;
        case (r_idx[1:0])
            2'd0:    ctl_rdata = {8'b0, GPIO_OUT, 3'b0, FORCE_FAN};
            2'd1:    ctl_rdata = 16'(STEP);
            2'd2:    ctl_rdata = 16'(UPDATE_CYCLE);
            default: ctl_rdata = VERSION;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s_cs_n       <= 1'b1;
            s_we_n       <= 1'b1;
            s_rd_n       <= 1'b1;
            s_bank       <= '0;
            s_idx        <= '0;
            s_data       <= '0;
            p_cs_n       <= 1'b1;
            p_we_n       <= 1'b1;
            p_bank       <= '0;
            p_idx        <= '0;
            p_data       <= '0;
            r_bank       <= '0;
            r_idx        <= '0;
            state        <= IDLE;
            cnt          <= '0;
            CPU_DATA_OUT <= '0;
            CPU_DATA_OE  <= 1'b0;
            TBL_WE       <= 1'b0;
            TBL_RE       <= 1'b0;
            TBL_SEL      <= '0;
            TBL_ADDR     <= '0;
            TBL_WDATA    <= '0;
            STEP         <= WIDTH'(STEP_RST);
            UPDATE_CYCLE <= WIDTH'(UPDATE_CYCLE_RST);
            FORCE_FAN    <= 1'b0;
            GPIO_OUT     <= '0;
        end else begin
            s_cs_n <= CPU_CS1_N;
            s_we_n <= CPU_WE0_N;
            s_rd_n <= CPU_RD_N;
            s_bank <= CPU_ADDR[15:14];
            s_idx  <= CPU_ADDR[7:0];
            s_data <= CPU_DATA_IN;
            p_cs_n <= s_cs_n;
            p_we_n <= s_we_n;
            p_bank <= s_bank;
            p_idx  <= s_idx;
            p_data <= s_data;
            TBL_WE <= 1'b0;
            TBL_RE <= 1'b0;

            // address/data of a commit come from the last WE_N-low sample (P)
            if (commit && p_bank != 2'd0 && in_range(p_idx)) begin
                TBL_WE    <= 1'b1;
                TBL_SEL   <= p_bank;
                TBL_ADDR  <= p_idx;
                TBL_WDATA <= p_data;
            end
            if (commit && p_bank == 2'd0) begin
                case (p_idx[1:0])
                    2'd0: begin
                        FORCE_FAN <= p_data[0];
                        GPIO_OUT  <= p_data[7:4];
                    end
                    2'd1:    STEP         <= p_data[WIDTH-1:0];
                    2'd2:    UPDATE_CYCLE <= p_data[WIDTH-1:0];
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (rd_start) begin
                        state  <= ISSUE;
                        r_bank <= s_bank;
                        r_idx  <= s_idx;
                        if (s_bank != 2'd0 && in_range(s_idx)) begin
                            TBL_RE   <= 1'b1;
                            TBL_SEL  <= s_bank;
                            TBL_ADDR <= s_idx;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= rd_hold ? WAIT : IDLE;
                end
                WAIT: begin
                    if (!rd_hold) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state       <= DRIVE;
                        CPU_DATA_OE <= 1'b1;
                        if (r_bank == 2'd0)
                            CPU_DATA_OUT <= ctl_rdata;
                        else
                            CPU_DATA_OUT <= in_range(r_idx) ? TBL_RDATA : 16'h0000;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (!rd_hold) begin
                        state       <= IDLE;
                        CPU_DATA_OE <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: bus write/read tasks, table model with 2-cycle latency.
module tb_cpu_bus_responder;

    localparam int WIDTH = 13;

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;
    logic [15:0]      CPU_ADDR = '0;
    logic [15:0]      CPU_DATA_IN = '0;
    logic [15:0]      CPU_DATA_OUT;
    logic             CPU_DATA_OE;
    logic             CPU_CS1_N = 1'b1;
    logic             CPU_WE0_N = 1'b1;
    logic             CPU_RD_N = 1'b1;
    logic             TBL_WE, TBL_RE;
    logic [1:0]       TBL_SEL;
    logic [7:0]       TBL_ADDR;
    logic [15:0]      TBL_WDATA;
    logic [15:0]      TBL_RDATA = 16'hDEAD;
    logic [WIDTH-1:0] STEP, UPDATE_CYCLE;
    logic             FORCE_FAN;
    logic [3:0]       GPIO_OUT;

    int n_cmp = 0;
    int n_err = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    logic [1:0]  we_sel, re_sel;
    logic [7:0]  we_addr, re_addr;
    logic [15:0] we_data;
    logic [15:0] rd_stage = 16'hDEAD;
    logic [15:0] rdat;
    int          lat;
    int          oe_seen;

    cpu_bus_responder #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CPU_ADDR(CPU_ADDR), .CPU_DATA_IN(CPU_DATA_IN),
        .CPU_DATA_OUT(CPU_DATA_OUT), .CPU_DATA_OE(CPU_DATA_OE), .CPU_CS1_N(CPU_CS1_N),
        .CPU_WE0_N(CPU_WE0_N), .CPU_RD_N(CPU_RD_N), .TBL_WE(TBL_WE), .TBL_RE(TBL_RE),
        .TBL_SEL(TBL_SEL), .TBL_ADDR(TBL_ADDR), .TBL_WDATA(TBL_WDATA), .TBL_RDATA(TBL_RDATA),
        .STEP(STEP), .UPDATE_CYCLE(UPDATE_CYCLE), .FORCE_FAN(FORCE_FAN), .GPIO_OUT(GPIO_OUT)
    );

    always #5 CLK = ~CLK;

    // table: data valid two cycles after the read pulse, a recognisable function of sel/index
    always @(posedge CLK) begin
        rd_stage  <= TBL_RE ? ({TBL_SEL, 6'd0, TBL_ADDR} ^ 16'hA500) : 16'hDEAD;
        TBL_RDATA <= rd_stage;
    end

    always @(negedge CLK) begin
        if (TBL_WE) begin
            we_cnt++;
            we_sel  = TBL_SEL;
            we_addr = TBL_ADDR;
            we_data = TBL_WDATA;
        end
        if (TBL_RE) begin
            re_cnt++;
            re_sel  = TBL_SEL;
            re_addr = TBL_ADDR;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive a write up to the WE_N rise; CS_N still low on return
    task automatic wr_strobe(input logic [15:0] a, input logic [15:0] d);
        @(negedge CLK);
        CPU_ADDR    = a;
        CPU_DATA_IN = d;
        CPU_CS1_N   = 1'b0;
        CPU_WE0_N   = 1'b0;
        repeat (2) @(negedge CLK);
        CPU_WE0_N = 1'b1;
    endtask

    task automatic wr_end();
        @(negedge CLK);
        CPU_CS1_N = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        wr_strobe(a, d);
        wr_end();
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output int l);
        @(negedge CLK);
        CPU_ADDR  = a;
        CPU_CS1_N = 1'b0;
        CPU_RD_N  = 1'b0;
        l = 0;
        while (!CPU_DATA_OE && l < 20) begin
            @(posedge CLK);
            #1;
            l++;
        end
        d = CPU_DATA_OUT;
        @(negedge CLK);
        CPU_RD_N  = 1'b1;
        CPU_CS1_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rd_oe_release", CPU_DATA_OE, 0);
        @(negedge CLK);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("rst_oe", CPU_DATA_OE, 0);
        check("rst_dout", CPU_DATA_OUT, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (5) @(negedge CLK);
        check("idle_step", STEP, 100);
        check("idle_upd", UPDATE_CYCLE, 1250);
        check("idle_oe", CPU_DATA_OE, 0);
        check("idle_fan", FORCE_FAN, 0);
        check("idle_gpio", GPIO_OUT, 0);
        check("idle_we_cnt", we_cnt, 0);
        check("idle_re_cnt", re_cnt, 0);

        bus_write(16'h8005, 16'h09C4);
        check("tw_cnt", we_cnt, 1);
        check("tw_sel", we_sel, 2);
        check("tw_addr", we_addr, 5);
        check("tw_data", we_data, 16'h09C4);

        wr_strobe(16'h0001, 16'hFFFF);
        @(posedge CLK); #1;
        check("step_1clk", STEP, 100);
        @(posedge CLK); #1;
        check("step_2clk", STEP, 13'h1FFF);
        wr_end();
        bus_read(16'h0001, rdat, lat);
        check("r1_data", rdat, 16'h1FFF);
        check("r1_lat", lat, 5);
        check("r1_no_re", re_cnt, 0);

        bus_write(16'h40F9, 16'h1234);
        check("oor_no_we", we_cnt, 1);
        bus_read(16'h40F9, rdat, lat);
        check("oor_data", rdat, 16'h0000);
        check("oor_no_re", re_cnt, 0);

        bus_write(16'h0000, 16'h00F1);
        check("r0_fan", FORCE_FAN, 1);
        check("r0_gpio", GPIO_OUT, 4'hF);
        bus_read(16'h0000, rdat, lat);
        check("r0_data", rdat, 16'h00F1);
        bus_write(16'h0002, 16'h0400);
        check("r2_upd", UPDATE_CYCLE, 13'h0400);
        bus_read(16'h0002, rdat, lat);
        check("r2_data", rdat, 16'h0400);
        bus_write(16'h0003, 16'h1234);
        bus_read(16'h0003, rdat, lat);
        check("r3_version", rdat, 16'h0001);
        check("r3_lat", lat, 5);
        check("ctl_no_we", we_cnt, 1);

        bus_read(16'hC007, rdat, lat);
        check("t3_data", rdat, 16'h6507);
        check("t3_lat", lat, 5);
        check("t3_re_cnt", re_cnt, 1);
        check("t3_re_sel", re_sel, 3);
        check("t3_re_addr", re_addr, 7);

        // RD_N released while the FSM waits on the table
        @(negedge CLK);
        CPU_ADDR  = 16'hC000;
        CPU_CS1_N = 1'b0;
        CPU_RD_N  = 1'b0;
        repeat (3) @(negedge CLK);
        CPU_RD_N  = 1'b1;
        CPU_CS1_N = 1'b1;
        oe_seen = 0;
        repeat (10) begin
            @(posedge CLK); #1;
            if (CPU_DATA_OE) oe_seen++;
        end
        check("abort_oe", oe_seen, 0);
        check("abort_re_cnt", re_cnt, 2);
        bus_read(16'h0003, rdat, lat);
        check("abort_next_data", rdat, 16'h0001);
        check("abort_next_lat", lat, 5);

        // reset while driving
        @(negedge CLK);
        CPU_ADDR  = 16'h0001;
        CPU_CS1_N = 1'b0;
        CPU_RD_N  = 1'b0;
        lat = 0;
        while (!CPU_DATA_OE && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
        check("drive_oe", CPU_DATA_OE, 1);
        #1;
        RESET_N = 1'b0;
        #1;
        check("arst_oe", CPU_DATA_OE, 0);
        check("arst_step", STEP, 100);
        check("arst_upd", UPDATE_CYCLE, 1250);
        check("arst_fan", FORCE_FAN, 0);
        check("arst_gpio", GPIO_OUT, 0);
        CPU_RD_N  = 1'b1;
        CPU_CS1_N = 1'b1;
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (4) @(negedge CLK);
        check("post_rst_oe", CPU_DATA_OE, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
